// File: rtl/uart_echo_buffer.sv
// Buffered byte bridge from a UART receiver to a UART transmitter.
// Each rising RX_READY edge queues one word; the queue drains into the transmitter as it goes idle.
module uart_echo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         RX_DATA,
    input  logic                          RX_READY,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_DATA_READY,
    input  logic                          TX_IDLE,
    input  logic                          FLUSH,
    output logic [$clog2(FIFO_DEPTH):0]   FILL_LEVEL,
    output logic                          OVERFLOW,
    output logic [CNT_WIDTH-1:0]          DROP_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]          LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_READY,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    prev_rx_ready;
    logic                    push_req;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    // Transmit handshake: TX_DATA_READY pulses for one cycle with TX_DATA valid, the
    // transmitter acknowledges by dropping TX_IDLE and signals completion by raising it again.
    assign push_req = RX_READY & ~prev_rx_ready;
    assign pop      = (state == S_READY) && (FILL_LEVEL != '0) && TX_IDLE;
    assign push_ok  = push_req && !FLUSH && ((FILL_LEVEL < DEPTH_LVL) || pop);
    assign drop     = push_req && !FLUSH && !push_ok;

    // Storage needs no reset; occupancy is tracked by the pointers and FILL_LEVEL.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= RX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FILL_LEVEL <= '0;
        end else if (FLUSH) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FILL_LEVEL <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   FILL_LEVEL <= FILL_LEVEL + LVL_ONE;
                2'b01:   FILL_LEVEL <= FILL_LEVEL - LVL_ONE;
                default: FILL_LEVEL <= FILL_LEVEL;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_READY;
            TX_DATA       <= '0;
            TX_DATA_READY <= 1'b0;
        end else begin
            TX_DATA_READY <= 1'b0;
            case (state)
                S_READY: begin
                    if (pop) begin
                        TX_DATA       <= mem[rd_ptr];
                        TX_DATA_READY <= 1'b1;
                        state         <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!TX_IDLE) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (TX_IDLE) begin
                        state <= S_READY;
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

    // prev_rx_ready resets high so a level already present at reset release is ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_rx_ready <= 1'b1;
            OVERFLOW      <= 1'b0;
            DROP_COUNT    <= '0;
        end else begin
            prev_rx_ready <= RX_READY;
            if (drop) begin
                OVERFLOW <= 1'b1;
                if (DROP_COUNT != '1) begin
                    DROP_COUNT <= DROP_COUNT + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: vector table for the overflow fill sequence, hand sequences for the
// multi-cycle corners, and a queue of expected transmitted words checked on every send pulse.
module tb_uart_echo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int NVEC  = 18;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_DATA;
    logic          RX_READY;
    logic [DW-1:0] TX_DATA;
    logic          TX_DATA_READY;
    logic          TX_IDLE;
    logic          FLUSH;
    logic [LW-1:0] FILL_LEVEL;
    logic          OVERFLOW;
    logic [CW-1:0] DROP_COUNT;

    logic          tx_auto;
    logic          tx_idle_man;
    logic          model_idle;
    int            busy_left;
    int            tx_busy_cycles;

    int            errors = 0;
    int            checks = 0;
    int            pulses = 0;
    logic          track_peak;
    int            peak;
    int            p0;
    logic [DW-1:0] sb_exp;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic          accept;
        logic [LW-1:0] exp_fill;
        logic          exp_ovf;
        logic [CW-1:0] exp_drop;
    } vec_t;
    vec_t vecs[NVEC];

    uart_echo_buffer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_DATA      (RX_DATA),
        .RX_READY     (RX_READY),
        .TX_DATA      (TX_DATA),
        .TX_DATA_READY(TX_DATA_READY),
        .TX_IDLE      (TX_IDLE),
        .FLUSH        (FLUSH),
        .FILL_LEVEL   (FILL_LEVEL),
        .OVERFLOW     (OVERFLOW),
        .DROP_COUNT   (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    assign TX_IDLE = tx_auto ? model_idle : tx_idle_man;

    // Transmitter model: busy for tx_busy_cycles after each send request.
    always @(negedge CLK) begin
        if (!tx_auto) begin
            busy_left  = 0;
            model_idle = 1'b1;
        end else if (TX_DATA_READY === 1'b1) begin
            busy_left  = tx_busy_cycles;
            model_idle = 1'b0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) model_idle = 1'b1;
        end
    end

    // Scoreboard: every send pulse must match the oldest expected word.
    always @(negedge CLK) begin
        if (TX_DATA_READY === 1'b1) begin
            pulses = pulses + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL tx_unexpected: got send of %02h, expected no send", TX_DATA);
            end else begin
                sb_exp = exp_q.pop_front();
                if (TX_DATA !== sb_exp) begin
                    errors = errors + 1;
                    $display("FAIL tx_order: got %02h, expected %02h", TX_DATA, sb_exp);
                end
            end
        end
        if (track_peak && int'(FILL_LEVEL) > peak) peak = int'(FILL_LEVEL);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish within time limit, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rx_word(input logic [DW-1:0] d, input bit expect_send);
        RX_DATA  = d;
        RX_READY = 1'b1;
        if (expect_send) exp_q.push_back(d);
        step();
        RX_READY = 1'b0;
        step();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && FILL_LEVEL == '0 && TX_IDLE === 1'b1) && n < budget) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 1);
        check({name, "_queue_left"}, 32'(exp_q.size()), 0);
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].data     = DW'(8'h10 + i);
            vecs[i].accept   = (i < DEPTH);
            vecs[i].exp_fill = LW'((i < DEPTH) ? i + 1 : DEPTH);
            vecs[i].exp_ovf  = (i >= DEPTH);
            vecs[i].exp_drop = CW'((i >= DEPTH) ? i - DEPTH + 1 : 0);
        end

        RST            = 1'b1;
        RX_DATA        = '0;
        RX_READY       = 1'b1;
        FLUSH          = 1'b0;
        tx_auto        = 1'b0;
        tx_idle_man    = 1'b1;
        tx_busy_cycles = 100;
        track_peak     = 1'b0;
        peak           = 0;

        // Reset values, with RX_READY held high through release.
        repeat (3) step();
        check("rst_tx_data", 32'(TX_DATA), 0);
        check("rst_tx_ready", 32'(TX_DATA_READY), 0);
        check("rst_fill", 32'(FILL_LEVEL), 0);
        check("rst_overflow", 32'(OVERFLOW), 0);
        check("rst_drop", 32'(DROP_COUNT), 0);
        RST = 1'b0;
        repeat (3) step();
        check("held_high_no_push", 32'(FILL_LEVEL), 0);
        check("held_high_no_send", 32'(pulses), 0);
        RX_READY = 1'b0;
        step();

        // Single echo with minimum latency.
        RX_DATA  = 8'h41;
        RX_READY = 1'b1;
        exp_q.push_back(8'h41);
        step();
        check("echo_fill_after_push", 32'(FILL_LEVEL), 1);
        check("echo_no_pulse_yet", 32'(TX_DATA_READY), 0);
        RX_READY = 1'b0;
        step();
        check("echo_pulse", 32'(TX_DATA_READY), 1);
        check("echo_data", 32'(TX_DATA), 32'h41);
        check("echo_fill_after_pop", 32'(FILL_LEVEL), 0);
        step();
        check("echo_pulse_one_cycle", 32'(TX_DATA_READY), 0);
        check("echo_data_held", 32'(TX_DATA), 32'h41);
        tx_idle_man = 1'b0;
        step();
        tx_idle_man = 1'b1;
        repeat (2) step();

        // Burst of five words into a slow transmitter.
        p0             = pulses;
        tx_busy_cycles = 100;
        tx_auto        = 1'b1;
        peak           = 0;
        track_peak     = 1'b1;
        for (int i = 1; i <= 5; i++) rx_word(DW'(i), 1'b1);
        wait_drain(1500, "burst");
        track_peak = 1'b0;
        check("burst_peak_fill", 32'(peak), 4);
        check("burst_pulses", 32'(pulses - p0), 5);
        check("burst_overflow", 32'(OVERFLOW), 0);

        // Overflow table: transmitter held busy, 18 words into a 16-deep queue.
        tx_auto     = 1'b0;
        tx_idle_man = 1'b0;
        step();
        p0 = pulses;
        for (int i = 0; i < NVEC; i++) begin
            RX_DATA  = vecs[i].data;
            RX_READY = 1'b1;
            if (vecs[i].accept) exp_q.push_back(vecs[i].data);
            step();
            check($sformatf("ovf_fill[%0d]", i), 32'(FILL_LEVEL), 32'(vecs[i].exp_fill));
            check($sformatf("ovf_flag[%0d]", i), 32'(OVERFLOW), 32'(vecs[i].exp_ovf));
            check($sformatf("ovf_drop[%0d]", i), 32'(DROP_COUNT), 32'(vecs[i].exp_drop));
            RX_READY = 1'b0;
            step();
        end

        // Full queue: push and pop on the same edge.
        tx_busy_cycles = 3;
        tx_auto        = 1'b1;
        RX_DATA        = 8'hA5;
        RX_READY       = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        check("full_pp_fill", 32'(FILL_LEVEL), DEPTH);
        check("full_pp_drop", 32'(DROP_COUNT), 2);
        check("full_pp_pulse", 32'(TX_DATA_READY), 1);
        RX_READY = 1'b0;
        wait_drain(2000, "ovf_drain");
        check("ovf_drain_pulses", 32'(pulses - p0), DEPTH + 1);
        check("ovf_sticky", 32'(OVERFLOW), 1);
        check("ovf_drop_final", 32'(DROP_COUNT), 2);

        // Flush with a send in flight; a push request on the flush edge is discarded.
        tx_busy_cycles = 20;
        p0 = pulses;
        rx_word(8'h61, 1'b1);
        rx_word(8'h62, 1'b0);
        rx_word(8'h63, 1'b0);
        rx_word(8'h64, 1'b0);
        check("flush_pre_fill", 32'(FILL_LEVEL), 3);
        FLUSH    = 1'b1;
        RX_DATA  = 8'hEE;
        RX_READY = 1'b1;
        step();
        check("flush_fill", 32'(FILL_LEVEL), 0);
        check("flush_drop", 32'(DROP_COUNT), 2);
        FLUSH    = 1'b0;
        RX_READY = 1'b0;
        repeat (60) step();
        check("flush_pulses", 32'(pulses - p0), 1);
        check("flush_fill_after", 32'(FILL_LEVEL), 0);
        check("flush_tx_data_held", 32'(TX_DATA), 32'h61);
        check("flush_queue_left", 32'(exp_q.size()), 0);

        // Reset while the send FSM waits for transmit completion.
        tx_busy_cycles = 50;
        rx_word(8'h71, 1'b1);
        rx_word(8'h72, 1'b0);
        repeat (3) step();
        check("rst_mid_pre_fill", 32'(FILL_LEVEL), 1);
        RST = 1'b1;
        step();
        check("rst_mid_tx_ready", 32'(TX_DATA_READY), 0);
        check("rst_mid_fill", 32'(FILL_LEVEL), 0);
        check("rst_mid_overflow", 32'(OVERFLOW), 0);
        check("rst_mid_drop", 32'(DROP_COUNT), 0);
        check("rst_mid_tx_data", 32'(TX_DATA), 0);
        RST = 1'b0;
        repeat (5) step();
        check("rst_mid_fill_after", 32'(FILL_LEVEL), 0);
        check("final_queue_left", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Buffered, parametrised byte bridge between the UART receiver and the UART transmitter.
- Captures each new received word on the rising edge of the receiver's ready level and stores it in a FIFO of depth FIFO_DEPTH.
- Drains the FIFO into the transmitter with a handshake driven by the transmitter's IDLE status.
- Back-to-back received words are therefore not lost while the transmitter is busy; overflow is counted and flagged.

Parameters:
- DATA_WIDTH, 8, width of one received/transmitted word.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the saturating dropped-word counter.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_DATA  input  DATA_WIDTH  word from the receiver; valid while RX_READY is high.
- RX_READY  input  1  receiver ready level; each 0->1 transition marks one new word.
- TX_DATA  output  DATA_WIDTH  word to the transmitter; held stable between sends.
- TX_DATA_READY  output  1  one-cycle send-request pulse to the transmitter.
- TX_IDLE  input  1  transmitter idle status; 1 = may accept a word.
- FLUSH  input  1  synchronous FIFO clear.
- FILL_LEVEL  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- OVERFLOW  output  1  sticky flag; a word was dropped.
- DROP_COUNT  output  CNT_WIDTH  number of dropped words; saturates at all-ones.

Behaviour:
- Reset values:
  - TX_DATA=0, TX_DATA_READY=0, FILL_LEVEL=0, OVERFLOW=0, DROP_COUNT=0.
  - FIFO pointers=0, send FSM=S_READY.
  - Internal prev_rx_ready=1, so an RX_READY held high across reset release is not captured.
- Edge detect:
  - push_req = RX_READY & ~prev_rx_ready.
  - prev_rx_ready <= RX_READY every cycle.
- Push:
  - On an edge with push_req=1, RX_DATA is written at the write pointer and the pointer increments, wrapping at FIFO_DEPTH.
  - A push is accepted if FILL_LEVEL<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped: OVERFLOW<=1 and DROP_COUNT increments unless already all-ones. FIFO contents are unchanged.
- Send FSM, three states:
  - S_READY: if FILL_LEVEL>0 and TX_IDLE=1, pop the head word: TX_DATA<=head, TX_DATA_READY<=1, read pointer increments with wrap, go to S_WAIT_BUSY.
  - S_WAIT_BUSY: TX_DATA_READY<=0. Stay until TX_IDLE=0, then go to S_WAIT_DONE.
  - S_WAIT_DONE: stay until TX_IDLE=1, then go to S_READY.
- TX_DATA_READY is high for exactly one cycle per popped word. TX_DATA is never changed outside a pop.
- Latency: RX_READY sampled rising at edge N -> word written at edge N. With an empty FIFO, S_READY and TX_IDLE=1, TX_DATA_READY is high after edge N+1 (2-cycle minimum).
- FILL_LEVEL arithmetic:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous accepted push and pop, including when FILL_LEVEL=FIFO_DEPTH and when FILL_LEVEL=0 (push then pop on a later edge; no bypass).
- Ordering: strict FIFO order; no reordering or duplication.
- FLUSH:
  - Clears both pointers and FILL_LEVEL on that edge.
  - A push_req on the same edge is discarded and not counted as dropped.
  - Does not affect the send FSM, TX_DATA, OVERFLOW or DROP_COUNT; a send in flight completes normally.
- OVERFLOW and DROP_COUNT clear only on RST.
- RST mid-operation: all state returns to reset values on the next edge, regardless of FSM state. FIFO contents need not be cleared.

Test Plan:
- Single echo: RST released, TX_IDLE=1; RX_DATA=0x41, RX_READY rises at edge N -> TX_DATA=0x41 and TX_DATA_READY=1 for exactly one cycle after edge N+1; FILL_LEVEL back to 0.
- Burst buffering:
  - Stimulus: TX_IDLE model busy 100 cycles per word; 5 RX_READY edges with 0x01..0x05.
  - Required: FILL_LEVEL peaks at 4; TX_DATA emits 0x01..0x05 in order; one TX_DATA_READY pulse each; OVERFLOW=0.
- Overflow:
  - Stimulus: TX_IDLE=0 held; 18 RX edges with FIFO_DEPTH=16.
  - Required: FILL_LEVEL=16, OVERFLOW=1, DROP_COUNT=2.
  - Follow-up: release TX_IDLE -> first 16 words sent in order; words 17-18 never appear.
- Full push+pop: with FILL_LEVEL=16, an RX edge on the same cycle as a pop -> word accepted, FILL_LEVEL stays 16, DROP_COUNT unchanged.
- Reset corner:
  - Stimulus: RX_READY held high through reset release.
  - Required: no push; FILL_LEVEL=0; the next 0->1 edge is captured.
  - Stimulus: RST asserted while in S_WAIT_DONE.
  - Required: TX_DATA_READY=0, FILL_LEVEL=0, OVERFLOW=0 after that edge.
- Flush: 3 words queued, one send in flight, FLUSH pulsed -> FILL_LEVEL=0; the in-flight send completes; no further TX_DATA_READY pulses; DROP_COUNT unchanged.
